// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (A) and DMA (B) share one single-cycle memory.
// Fair round-robin on ties, optional locked bursts of up to MAX_BURST beats, registered responses.
module dmem_arbiter #(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_lock,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_err,

    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_lock,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_err,

    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned BW       = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_B  = BW'(MAX_BURST);
    localparam bit          CAN_LOCK = (MAX_BURST > 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_t;

    state_t        state, state_nx;
    port_t         last, last_nx;
    logic [BW-1:0] beats, beats_nx;
    logic [BW-1:0] beat_inc;

    logic          any_gnt;
    logic          sel_we;
    logic          sel_lock;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          in_range;

    // Grant decision; reset gates everything so nothing can commit while rst is high.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (a_req && b_req) begin
                        if (last == PORT_B) a_gnt = 1'b1;
                        else                b_gnt = 1'b1;
                    end else begin
                        a_gnt = a_req;
                        b_gnt = b_req;
                    end
                end
                OWN_A:   a_gnt = a_req;
                OWN_B:   b_gnt = b_req;
                default: ;
            endcase
        end
    end

    assign any_gnt   = a_gnt | b_gnt;
    assign sel_we    = b_gnt ? b_we    : a_we;
    assign sel_lock  = b_gnt ? b_lock  : a_lock;
    assign sel_addr  = b_gnt ? b_addr  : a_addr;
    assign sel_wdata = b_gnt ? b_wdata : a_wdata;
    assign in_range  = (sel_addr < DEPTH);

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any_gnt && in_range) begin
            mem_read  = !sel_we;
            mem_write = sel_we;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
        end
    end

    assign beat_inc = beats + 1'b1;

    always_comb begin
        state_nx = state;
        beats_nx = beats;
        last_nx  = last;
        if (any_gnt) last_nx = b_gnt ? PORT_B : PORT_A;
        unique case (state)
            IDLE: begin
                beats_nx = '0;
                if (any_gnt && sel_lock && CAN_LOCK) begin
                    state_nx = b_gnt ? OWN_B : OWN_A;
                    beats_nx = BW'(1);
                end
            end
            OWN_A, OWN_B: begin
                // Only the owner can be granted here, so any_gnt means an owner beat.
                if (any_gnt && sel_lock && (beat_inc < MAX_B)) begin
                    beats_nx = beat_inc;
                end else begin
                    state_nx = IDLE;
                    beats_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                beats_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= PORT_B;
            beats <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            beats <= beats_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            a_err    <= 1'b0;
            a_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_err    <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt;
            a_err    <= a_gnt && !in_range;
            a_rdata  <= (a_gnt && in_range && !sel_we) ? mem_rdata : '0;
            b_rvalid <= b_gnt;
            b_err    <= b_gnt && !in_range;
            b_rdata  <= (b_gnt && in_range && !sel_we) ? mem_rdata : '0;
        end
    end

endmodule
